keypad_entry_controller: RTL and testbench
==========================================

Name: keypad_entry_controller

Overview:
Sequences raw keypad activity into a complete multi-digit answer for the game FSM. Sits between pmod_keypad (key_detected/key value) and the game state machine. Debounces presses, edits a digit buffer (append and backspace), and presents the finished entry to the game FSM over a valid/ready handshake. Replaces ad-hoc edge detection and digit counting in the game FSM.

Parameters:
DIGITS, 4, number of BCD digits per entry (1..7)
DEBOUNCE_CYCLES, 100000, consecutive stable samples needed to accept a press or a release (>=2)
TIMEOUT_CYCLES, 200000000, inactivity limit for the optional timeout
CNT_W, 28, width of the internal debounce and timeout counters

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
enable  in  1  entry armed; game FSM drives high while waiting for input
key_detected  in  1  level from pmod_keypad, high while a key is held
key_value  in  4  key code from pmod_keypad, valid when key_detected is high
entry_ready  in  1  consumer can accept an entry
entry_valid  out  1  entry_data holds a complete entry
entry_data  out  4*DIGITS  packed digits, first-typed digit in the MS nibble
digit_count  out  3  digits currently held (0..DIGITS)
key_pulse  out  1  one-cycle strobe per accepted press of any key
timeout  out  1  one-cycle strobe on inactivity clear (optional feature)

Behaviour:
- Reset values: all outputs 0, buffer 0, counters 0, state IDLE.
- States: IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, PRESENT.
- IDLE: go to WAIT_PRESS when enable=1.
- WAIT_PRESS: on key_detected=1, latch key_value into cand, clear cnt, go to DEBOUNCE.
- DEBOUNCE: each cycle, key_detected=1 with key_value==cand increments cnt. key_detected=0 returns to WAIT_PRESS with no action. key_value!=cand relatches cand and clears cnt.
- A press is accepted on the DEBOUNCE_CYCLES-th consecutive stable sample. key_pulse is high for the next cycle only, the action is applied in that cycle, and the state goes to WAIT_RELEASE.
- Actions:
  - 0-9: buffer <= {buffer[4*DIGITS-5:0], key}; count+1.
  - 14 (backspace): buffer >> 4; count-1; no-op on the buffer when count=0.
  - 10-13 and 15: key_pulse only, no buffer change.
- WAIT_RELEASE: needs DEBOUNCE_CYCLES consecutive key_detected=0 samples. Any high sample restarts the count; a held key never repeats. Then:
  - count==DIGITS: go to PRESENT.
  - otherwise: go to WAIT_PRESS.
- PRESENT: entry_valid=1; entry_data = buffer, zero-extended in low-order position per shift rule and stable.
  - Transfer happens on a cycle with entry_valid and entry_ready both high.
  - On transfer: next cycle entry_valid=0, buffer=0, count=0, state WAIT_PRESS if enable else IDLE.
  - Keypad input is ignored in PRESENT.
  - entry_valid never drops without a transfer, even if enable falls.
- enable=0 in any state except PRESENT: next cycle clear buffer, count and cnt, go to IDLE. key_pulse is suppressed.
- entry_ready is ignored outside PRESENT. entry_valid is registered, so there is no combinational path from entry_ready.
- rst has priority over every event, including a mid-debounce press and a pending entry.
- Counters saturate and never wrap.

Optional Feature:
ENTRY_TIMEOUT_EN
- Defined: a timer clears on every accepted press and counts whenever count>0 in WAIT_PRESS, DEBOUNCE or WAIT_RELEASE.
- When the timer reaches TIMEOUT_CYCLES: timeout=1 for one cycle, buffer and count clear, state goes to WAIT_RELEASE if key_detected is high, else WAIT_PRESS.
- The timer is held at 0 in IDLE and PRESENT.
- Undefined: timeout is tied to 0 and no timer logic exists.

Test Plan:
- Reset hold: rst=1 for 3 cycles with key_detected=1 -> all outputs 0 and state IDLE; then enable=1 -> press accepted only after a full debounce.
- Sequence 1,2,3,4 (DEBOUNCE_CYCLES=4, each key 8 cycles high, 8 low) with entry_ready=0 -> key_pulse 4 times, digit_count 1..4, entry_valid=1 with entry_data=16'h1234 held stable for 20 cycles; assert entry_ready -> one transfer, next cycle entry_valid=0 and digit_count=0.
- Bounce: key high 3 cycles, low 1, high 4 -> exactly one key_pulse, on the final stable run; a 3-cycle glitch alone -> no key_pulse.
- Edit: keys 5,7,E,9,1,2 -> entry_data=16'h5912; a leading E at count 0 -> key_pulse=1, digit_count stays 0.
- Abort: enable=0 after 2 digits -> next cycle digit_count=0 and state IDLE; enable=0 during PRESENT -> entry_valid stays 1 until entry_ready.
- ENTRY_TIMEOUT_EN (TIMEOUT_CYCLES=50): one digit, then idle 50 cycles -> timeout pulse, digit_count=0; undefined build -> digit retained and timeout stays 0.

Source files
------------

// File: rtl/keypad_entry_controller.sv
// Debounces keypad presses into a BCD digit buffer and hands complete entries over valid/ready.
// Define ENTRY_TIMEOUT_EN to add an inactivity timer that clears a partial entry.
module keypad_entry_controller #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int TIMEOUT_CYCLES  = 200000000,
    parameter int CNT_W           = 28
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic                key_detected,
    input  logic [3:0]          key_value,
    input  logic                entry_ready,
    output logic                entry_valid,
    output logic [4*DIGITS-1:0] entry_data,
    output logic [2:0]          digit_count,
    output logic                key_pulse,
    output logic                timeout
);
    typedef enum logic [2:0] {IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE, PRESENT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX      = {CNT_W{1'b1}};
    // The sample that enters DEBOUNCE already counts as the first stable one.
    localparam logic [CNT_W-1:0] PRESS_LAST   = CNT_W'(DEBOUNCE_CYCLES - 2);
    localparam logic [CNT_W-1:0] RELEASE_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [2:0]       FULL         = 3'(DIGITS);
    localparam logic [3:0]       KEY_BACK     = 4'd14;

    state_t              state, state_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [3:0]          cand, cand_next;
    logic [4*DIGITS-1:0] buffer, buffer_next;
    logic [2:0]          count, count_next;
    logic                valid_next, pulse_next;

`ifdef ENTRY_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] timer, timer_next;
    logic             timeout_next;
`endif

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        cand_next   = cand;
        buffer_next = buffer;
        count_next  = count;
        valid_next  = entry_valid;
        pulse_next  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
        timer_next   = timer;
        timeout_next = 1'b0;
`endif
        case (state)
            IDLE: if (enable) state_next = WAIT_PRESS;
            WAIT_PRESS: if (key_detected) begin
                cand_next  = key_value;
                cnt_next   = '0;
                state_next = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (!key_detected) begin
                    cnt_next   = '0;
                    state_next = WAIT_PRESS;
                end else if (key_value != cand) begin
                    cand_next = key_value;
                    cnt_next  = '0;
                end else if (cnt >= PRESS_LAST) begin
                    pulse_next = 1'b1;
                    cnt_next   = '0;
                    state_next = WAIT_RELEASE;
                    if (cand <= 4'd9) begin
                        buffer_next      = buffer << 4;
                        buffer_next[3:0] = cand;
                        count_next       = count + 3'd1;
                    end else if (cand == KEY_BACK && count != 3'd0) begin
                        buffer_next = buffer >> 4;
                        count_next  = count - 3'd1;
                    end
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
            WAIT_RELEASE: begin
                if (key_detected) begin
                    cnt_next = '0;
                end else if (cnt >= RELEASE_LAST) begin
                    cnt_next   = '0;
                    valid_next = (count == FULL);
                    state_next = (count == FULL) ? PRESENT : WAIT_PRESS;
                end else begin
                    cnt_next = sat_inc(cnt);
                end
            end
            PRESENT: if (entry_ready) begin
                valid_next  = 1'b0;
                buffer_next = '0;
                count_next  = 3'd0;
                state_next  = enable ? WAIT_PRESS : IDLE;
            end
            default: state_next = IDLE;
        endcase

`ifdef ENTRY_TIMEOUT_EN
        // An accepted press wins over a timer expiry in the same cycle.
        if (state == IDLE || state == PRESENT || pulse_next) begin
            timer_next = '0;
        end else if (count != 3'd0) begin
            if (timer >= TIMEOUT_LAST) begin
                timer_next   = '0;
                timeout_next = 1'b1;
                buffer_next  = '0;
                count_next   = 3'd0;
                cnt_next     = '0;
                valid_next   = 1'b0;
                state_next   = key_detected ? WAIT_RELEASE : WAIT_PRESS;
            end else begin
                timer_next = sat_inc(timer);
            end
        end
`endif

        // A pending entry survives enable dropping; everything else is abandoned.
        if (!enable && state != PRESENT) begin
            state_next  = IDLE;
            buffer_next = '0;
            count_next  = 3'd0;
            cnt_next    = '0;
            pulse_next  = 1'b0;
            valid_next  = 1'b0;
`ifdef ENTRY_TIMEOUT_EN
            timer_next   = '0;
            timeout_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= '0;
            buffer      <= '0;
            count       <= 3'd0;
            entry_valid <= 1'b0;
            key_pulse   <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            cand        <= cand_next;
            buffer      <= buffer_next;
            count       <= count_next;
            entry_valid <= valid_next;
            key_pulse   <= pulse_next;
        end
    end

`ifdef ENTRY_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            timer   <= '0;
            timeout <= 1'b0;
        end else begin
            timer   <= timer_next;
            timeout <= timeout_next;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    assign entry_data  = buffer;
    assign digit_count = count;
endmodule

// File: tb/tb_keypad_entry_controller.sv
// Bench for keypad_entry_controller: directed scenarios plus randomized keypad traffic
// checked every cycle against a run-length/queue model of the entry rules.
module tb_keypad_entry_controller;
    localparam int DIGITS = 4;
    localparam int DEB    = 4;
    localparam int TMO    = 50;

    logic        clk = 1'b0;
    logic        rst, enable, key_detected, entry_ready;
    logic [3:0]  key_value;
    logic        entry_valid, key_pulse, timeout;
    logic [15:0] entry_data;
    logic [2:0]  digit_count;

    int compared   = 0;
    int mismatched = 0;
    int pulses_seen   = 0;
    int timeouts_seen = 0;

    // Reference model state: digits as a queue, debounce as sample run lengths.
    bit         model_live = 0;
    bit         m_armed, m_present, m_release, m_valid, m_pulse, m_timeout;
    int         m_run, m_low;
    logic [3:0] m_run_key;
    int         m_digits[$];
`ifdef ENTRY_TIMEOUT_EN
    int         m_timer;
    bit         was_live;
`endif

    keypad_entry_controller #(
        .DIGITS(DIGITS), .DEBOUNCE_CYCLES(DEB), .TIMEOUT_CYCLES(TMO), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .key_detected(key_detected),
        .key_value(key_value), .entry_ready(entry_ready), .entry_valid(entry_valid),
        .entry_data(entry_data), .digit_count(digit_count), .key_pulse(key_pulse),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_data();
        logic [31:0] d = 0;
        foreach (m_digits[i]) d = (d << 4) | 32'(m_digits[i]);
        return d;
    endfunction

    function automatic void check_output(input string name, input logic [31:0] act,
                                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_armed = 0; m_present = 0; m_release = 0; m_valid = 0;
            m_pulse = 0; m_timeout = 0; m_run = 0; m_low = 0; m_run_key = 0;
            m_digits.delete();
`ifdef ENTRY_TIMEOUT_EN
            m_timer = 0;
`endif
        end else begin
            m_pulse = 0;
            m_timeout = 0;
`ifdef ENTRY_TIMEOUT_EN
            was_live = m_armed && !m_present && enable;
`endif
            if (m_present) begin
                if (entry_ready) begin
                    m_present = 0; m_valid = 0; m_digits.delete();
                    m_armed = enable; m_release = 0; m_run = 0;
                end
            end else if (!enable) begin
                m_armed = 0; m_release = 0; m_run = 0; m_digits.delete();
            end else if (!m_armed) begin
                m_armed = 1; m_release = 0; m_run = 0;
            end else if (m_release) begin
                if (key_detected) m_low = 0;
                else begin
                    m_low++;
                    if (m_low == DEB) begin
                        m_release = 0; m_run = 0;
                        if (m_digits.size() == DIGITS) begin
                            m_present = 1; m_valid = 1;
                        end
                    end
                end
            end else begin
                if (!key_detected) m_run = 0;
                else if (m_run > 0 && key_value == m_run_key) m_run++;
                else begin
                    m_run = 1; m_run_key = key_value;
                end
                if (m_run == DEB) begin
                    m_pulse = 1; m_release = 1; m_low = 0; m_run = 0;
                    if (m_run_key <= 9) m_digits.push_back(int'(m_run_key));
                    else if (m_run_key == 14 && m_digits.size() > 0) void'(m_digits.pop_back());
                end
            end
`ifdef ENTRY_TIMEOUT_EN
            if (!was_live || m_pulse) m_timer = 0;
            else if (m_digits.size() > 0) begin
                m_timer++;
                if (m_timer == TMO) begin
                    m_timer = 0; m_timeout = 1; m_digits.delete();
                    m_present = 0; m_valid = 0; m_run = 0; m_low = 0;
                    m_release = key_detected;
                end
            end
`endif
        end
        model_live = 1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check_output("entry_valid", 32'(entry_valid), 32'(m_valid));
            check_output("digit_count", 32'(digit_count), 32'(m_digits.size()));
            check_output("key_pulse", 32'(key_pulse), 32'(m_pulse));
            check_output("timeout", 32'(timeout), 32'(m_timeout));
            if (m_valid) check_output("entry_data", 32'(entry_data), model_data());
        end
        if (key_pulse === 1'b1) pulses_seen++;
        if (timeout === 1'b1) timeouts_seen++;
    end

    task automatic apply_stimulus(input logic en, input logic kd, input logic [3:0] kv,
                                  input logic rdy, input int n);
        enable = en; key_detected = kd; key_value = kv; entry_ready = rdy;
        repeat (n) @(negedge clk);
    endtask

    task automatic press_key(input logic [3:0] k);
        apply_stimulus(1'b1, 1'b1, k, 1'b0, 8);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 8);
    endtask

    logic [3:0] others [5] = '{4'd10, 4'd11, 4'd12, 4'd13, 4'd15};
    logic [3:0] k;
    logic       en_r;
    int         hi, lo, glitch, r;

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b1, 4'd1, 1'b0, 3);
        check_output("reset_valid", 32'(entry_valid), 32'd0);
        check_output("reset_count", 32'(digit_count), 32'd0);
        check_output("reset_pulse", 32'(key_pulse), 32'd0);
        check_output("reset_data", 32'(entry_data), 32'd0);
        check_output("reset_timeout", 32'(timeout), 32'd0);
        rst = 1'b0;
        pulses_seen = 0;
        apply_stimulus(1'b1, 1'b1, 4'd1, 1'b0, 4);
        check_output("early_pulses", 32'(pulses_seen), 32'd0);
        apply_stimulus(1'b1, 1'b1, 4'd1, 1'b0, 1);
        check_output("first_accept", 32'(key_pulse), 32'd1);
        check_output("first_count", 32'(digit_count), 32'd1);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 8);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1);

        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1);
        pulses_seen = 0;
        press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
        check_output("seq_pulses", 32'(pulses_seen), 32'd4);
        for (int i = 0; i < 20; i++) begin
            check_output("seq_hold_valid", 32'(entry_valid), 32'd1);
            check_output("seq_hold_data", 32'(entry_data), 32'h1234);
            apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1);
        end
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1);
        check_output("xfer_valid", 32'(entry_valid), 32'd0);
        check_output("xfer_count", 32'(digit_count), 32'd0);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1);

        pulses_seen = 0;
        apply_stimulus(1'b1, 1'b1, 4'd10, 1'b0, 3);
        apply_stimulus(1'b1, 1'b0, 4'd10, 1'b0, 1);
        apply_stimulus(1'b1, 1'b1, 4'd10, 1'b0, 4);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 8);
        check_output("bounce_pulses", 32'(pulses_seen), 32'd1);
        apply_stimulus(1'b1, 1'b1, 4'd6, 1'b0, 3);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 8);
        check_output("glitch_pulses", 32'(pulses_seen), 32'd1);
        check_output("glitch_count", 32'(digit_count), 32'd0);

        pulses_seen = 0;
        press_key(4'd14);
        check_output("lead_back_pulse", 32'(pulses_seen), 32'd1);
        check_output("lead_back_count", 32'(digit_count), 32'd0);
        press_key(4'd5); press_key(4'd7); press_key(4'd14);
        check_output("edit_back_count", 32'(digit_count), 32'd1);
        press_key(4'd9); press_key(4'd1); press_key(4'd2);
        check_output("edit_valid", 32'(entry_valid), 32'd1);
        check_output("edit_data", 32'(entry_data), 32'h5912);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b1, 1);

        press_key(4'd3); press_key(4'd6);
        check_output("abort_before", 32'(digit_count), 32'd2);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1);
        check_output("abort_count", 32'(digit_count), 32'd0);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1);
        press_key(4'd1); press_key(4'd2); press_key(4'd3); press_key(4'd4);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 10);
        check_output("abort_present_valid", 32'(entry_valid), 32'd1);
        check_output("abort_present_data", 32'(entry_data), 32'h1234);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b1, 1);
        check_output("abort_xfer_valid", 32'(entry_valid), 32'd0);
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1);

        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 1);
        timeouts_seen = 0;
        press_key(4'd7);
        apply_stimulus(1'b1, 1'b0, 4'd0, 1'b0, 60);
`ifdef ENTRY_TIMEOUT_EN
        check_output("timeout_pulses", 32'(timeouts_seen), 32'd1);
        check_output("timeout_count", 32'(digit_count), 32'd0);
`else
        check_output("no_timeout_pulses", 32'(timeouts_seen), 32'd0);
        check_output("no_timeout_count", 32'(digit_count), 32'd1);
`endif
        apply_stimulus(1'b0, 1'b0, 4'd0, 1'b0, 1);

        for (int s = 0; s < 220; s++) begin
            en_r = ($urandom_range(0, 29) != 0);
            r = int'($urandom_range(0, 99));
            if (r < 70) k = 4'($urandom_range(0, 9));
            else if (r < 85) k = 4'd14;
            else k = others[$urandom_range(0, 4)];
            hi = int'($urandom_range(1, 7));
            lo = int'($urandom_range(1, 8));
            glitch = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, hi - 1)) : -1;
            for (int c = 0; c < hi; c++)
                apply_stimulus(en_r, 1'b1, (c == glitch) ? (k ^ 4'h3) : k,
                               ($urandom_range(0, 3) == 0), 1);
            for (int c = 0; c < lo; c++)
                apply_stimulus(en_r, 1'b0, 4'($urandom_range(0, 15)),
                               ($urandom_range(0, 3) == 0), 1);
            if ($urandom_range(0, 24) == 0)
                for (int c = 0; c < 55; c++)
                    apply_stimulus(1'b1, 1'b0, 4'd0, ($urandom_range(0, 3) == 0), 1);
            if (s == 110) begin
                rst = 1'b1;
                apply_stimulus(1'b1, 1'b1, k, 1'b0, 2);
                rst = 1'b0;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
